// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: encodings shared by the hazard controller and its record stages.
//   RegDst codes, MemtoReg codes, forward-select codes, Tuse levels and the
//   MemtoReg -> Tnew mapping used for the E-stage producer record.
package hazard_ctrl_pkg;

  // RegDstE encodings (11 selects no destination)
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // MemtoRegE encodings
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_DM  = 2'b01;
  localparam logic [1:0] M2R_PC8 = 2'b10;

  // Forward select codes
  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_M    = 2'b01;
  localparam logic [1:0] FWD_W    = 2'b10;
  localparam logic [1:0] FWD_PC8E = 2'b11;

  // Cycles until the consumer needs the operand; NONE never stalls
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Cycles until an E-stage producer's result exists
  function automatic logic [1:0] tnew_of(input logic [1:0] mem_to_reg);
    logic [1:0] t;
    case (mem_to_reg)
      M2R_DM:  t = 2'd2;
      M2R_ALU: t = 2'd1;
      default: t = 2'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/hazard_stage_rec.sv
// hazard_stage_rec: one registered {addr, tnew} destination record.
//   clk, reset  : pipeline clock, async active-high clear
//   addr_in     : destination register entering the stage
//   tnew_in     : Tnew of the previous stage; stored decremented, saturating at 0
//   addr, tnew  : record held for this stage
module hazard_stage_rec
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] addr_in,
  input  logic [1:0]        tnew_in,
  output logic [REG_AW-1:0] addr,
  output logic [1:0]        tnew
);

  logic [1:0] tnew_dec;

  always_comb begin
    tnew_dec = (tnew_in == 2'd0) ? 2'd0 : tnew_in - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
      tnew <= '0;
    end else begin
      addr <= addr_in;
      tnew <= tnew_dec;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward controller for the 5-stage MIPS pipeline (Tnew/Tuse).
//   Inputs : clk, reset (async, active-high), D-stage operand/class fields
//            (RsD, RtD, branchD, jrD, cal_rD, cal_iD, ldD, stD) and E-stage
//            control fields leaving ID/EX (RsE, RtE, RdE, RegDstE, RegWriteE, MemtoRegE).
//   Outputs: StallF, StallD, FlushE; ForwardRSD/RTD (D operands), ForwardRSE/RTE
//            (E operands), ForwardRTM (M store data).
//   M and W destination records are tracked internally; no feedback from EX/MEM or MEM/WB.
//   Optional macro HAZARD_PERF_EN adds stall_cnt / flush_cnt event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned RA_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic              branchD,
  input  logic              jrD,
  input  logic              cal_rD,
  input  logic              cal_iD,
  input  logic              ldD,
  input  logic              stD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] RdE,
  input  logic [1:0]        RegDstE,
  input  logic              RegWriteE,
  input  logic [1:0]        MemtoRegE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic [1:0]        ForwardRSD,
  output logic [1:0]        ForwardRTD,
  output logic [1:0]        ForwardRSE,
  output logic [1:0]        ForwardRTE,
  output logic              ForwardRTM
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic [REG_AW-1:0] addr_e, addr_m, addr_w, rt_m;
  logic [1:0]        tnew_e, tnew_m, tnew_w;
  logic [1:0]        tuse_rs, tuse_rt;
  logic              stall_rs, stall_rt, stall;
  logic [1:0]        fwd_rsd, fwd_rtd, fwd_rse, fwd_rte;
  logic              fwd_rtm;

  function automatic logic hit(input logic [REG_AW-1:0] addr, input logic [REG_AW-1:0] src);
    return (addr != '0) && (addr == src);
  endfunction

  // The nearest matching producer owns the register; if its result is not ready
  // yet, older stages hold stale data and must not be selected.
  function automatic logic [1:0] fwd_d_sel(input logic [REG_AW-1:0] src,
                                           input logic [REG_AW-1:0] ae, input logic [1:0] te,
                                           input logic [REG_AW-1:0] am, input logic [1:0] tm,
                                           input logic [REG_AW-1:0] aw, input logic [1:0] tw);
    logic [1:0] sel;
    if (hit(ae, src))      sel = (te == 2'd0) ? FWD_PC8E : FWD_RF;
    else if (hit(am, src)) sel = (tm == 2'd0) ? FWD_M : FWD_RF;
    else if (hit(aw, src)) sel = (tw == 2'd0) ? FWD_W : FWD_RF;
    else                   sel = FWD_RF;
    return sel;
  endfunction

  function automatic logic [1:0] fwd_e_sel(input logic [REG_AW-1:0] src,
                                           input logic [REG_AW-1:0] am, input logic [1:0] tm,
                                           input logic [REG_AW-1:0] aw, input logic [1:0] tw);
    logic [1:0] sel;
    if (hit(am, src))      sel = (tm == 2'd0) ? FWD_M : FWD_RF;
    else if (hit(aw, src)) sel = (tw == 2'd0) ? FWD_W : FWD_RF;
    else                   sel = FWD_RF;
    return sel;
  endfunction

  // E-stage producer record
  always_comb begin
    addr_e = '0;
    if (RegWriteE) begin
      case (RegDstE)
        RD_RT:   addr_e = RtE;
        RD_RD:   addr_e = RdE;
        RD_RA:   addr_e = REG_AW'(RA_REG);
        default: addr_e = '0;
      endcase
    end
    tnew_e = tnew_of(MemtoRegE);
  end

  // W receives Tnew of M decremented; M never exceeds 1, so W is always ready.
  hazard_stage_rec #(.REG_AW(REG_AW)) u_rec_m (
    .clk     (clk),
    .reset   (reset),
    .addr_in (addr_e),
    .tnew_in (tnew_e),
    .addr    (addr_m),
    .tnew    (tnew_m)
  );

  hazard_stage_rec #(.REG_AW(REG_AW)) u_rec_w (
    .clk     (clk),
    .reset   (reset),
    .addr_in (addr_m),
    .tnew_in (tnew_m),
    .addr    (addr_w),
    .tnew    (tnew_w)
  );

  // Store-data source register for the instruction now in M
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rt_m <= '0;
    else       rt_m <= RtE;
  end

  // Tuse per D operand
  always_comb begin
    if (branchD || jrD)                        tuse_rs = TUSE_0;
    else if (cal_rD || cal_iD || ldD || stD)   tuse_rs = TUSE_1;
    else                                       tuse_rs = TUSE_NONE;

    if (branchD)     tuse_rt = TUSE_0;
    else if (cal_rD) tuse_rt = TUSE_1;
    else if (stD)    tuse_rt = TUSE_2;
    else             tuse_rt = TUSE_NONE;
  end

  always_comb begin
    stall_rs = (hit(addr_e, RsD) && (tnew_e > tuse_rs)) ||
               (hit(addr_m, RsD) && (tnew_m > tuse_rs));
    stall_rt = (hit(addr_e, RtD) && (tnew_e > tuse_rt)) ||
               (hit(addr_m, RtD) && (tnew_m > tuse_rt));
    stall    = stall_rs || stall_rt;

    fwd_rsd = fwd_d_sel(RsD, addr_e, tnew_e, addr_m, tnew_m, addr_w, tnew_w);
    fwd_rtd = fwd_d_sel(RtD, addr_e, tnew_e, addr_m, tnew_m, addr_w, tnew_w);
    fwd_rse = fwd_e_sel(RsE, addr_m, tnew_m, addr_w, tnew_w);
    fwd_rte = fwd_e_sel(RtE, addr_m, tnew_m, addr_w, tnew_w);
    fwd_rtm = hit(addr_w, rt_m);
  end

  // Outputs are forced low for the whole reset window, not just after the records clear
  always_comb begin
    StallF     = stall && !reset;
    StallD     = stall && !reset;
    FlushE     = stall && !reset;
    ForwardRSD = reset ? FWD_RF : fwd_rsd;
    ForwardRTD = reset ? FWD_RF : fwd_rtd;
    ForwardRSE = reset ? FWD_RF : fwd_rse;
    ForwardRTE = reset ? FWD_RF : fwd_rte;
    ForwardRTM = fwd_rtm && !reset;
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallD) stall_cnt <= stall_cnt + 32'd1;
      if (FlushE) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized check of hazard_ctrl against a producer-age model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, RdE;
  logic       branchD, jrD, cal_rD, cal_iD, ldD, stD;
  logic [1:0] RegDstE, MemtoRegE;
  logic       RegWriteE;
  logic       StallF, StallD, FlushE, ForwardRTM;
  logic [1:0] ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .RA_REG(31)) dut (
    .clk        (clk),
    .reset      (reset),
    .RsD        (RsD),
    .RtD        (RtD),
    .branchD    (branchD),
    .jrD        (jrD),
    .cal_rD     (cal_rD),
    .cal_iD     (cal_iD),
    .ldD        (ldD),
    .stD        (stD),
    .RsE        (RsE),
    .RtE        (RtE),
    .RdE        (RdE),
    .RegDstE    (RegDstE),
    .RegWriteE  (RegWriteE),
    .MemtoRegE  (MemtoRegE),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushE     (FlushE),
    .ForwardRSD (ForwardRSD),
    .ForwardRTD (ForwardRTD),
    .ForwardRSE (ForwardRSE),
    .ForwardRTE (ForwardRTE),
    .ForwardRTM (ForwardRTM)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  // Model: every cycle one E-stage issue (possibly writing nothing) leaves E.
  // hist[0] issued one cycle ago (now in M), hist[1] two cycles ago (now in W).
  // An issue's remaining latency is its issue Tnew minus its age, floored at 0.
  typedef struct {
    logic [4:0] dest;
    int         tnew;
    logic [4:0] rt;
  } issue_t;
  issue_t hist[$];
  int unsigned m_scnt, m_fcnt;

  logic       x_stall, x_rtm;
  logic [1:0] x_rsd, x_rtd, x_rse, x_rte;

  function automatic bit hit(input logic [4:0] a, input logic [4:0] s);
    return (a != 5'd0) && (a == s);
  endfunction

  function automatic logic [4:0] e_dest();
    if (!RegWriteE) return 5'd0;
    case (RegDstE)
      2'b00:   return RtE;
      2'b01:   return RdE;
      2'b10:   return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  function automatic int e_tnew();
    return (MemtoRegE == 2'b01) ? 2 : (MemtoRegE == 2'b00) ? 1 : 0;
  endfunction

  function automatic int remain(input int tnew, input int age);
    return (tnew > age) ? tnew - age : 0;
  endfunction

  task automatic calc();
    logic [4:0] ea, ma, wa, rtm;
    int et, mt, wt, urs, urt;
    ea = e_dest(); et = e_tnew();
    ma = 5'd0; mt = 0; wa = 5'd0; wt = 0; rtm = 5'd0;
    if (hist.size() > 0) begin ma = hist[0].dest; mt = remain(hist[0].tnew, 1); rtm = hist[0].rt; end
    if (hist.size() > 1) begin wa = hist[1].dest; wt = remain(hist[1].tnew, 2); end
    urs = (branchD || jrD) ? 0 : (cal_rD || cal_iD || ldD || stD) ? 1 : 3;
    urt = branchD ? 0 : cal_rD ? 1 : stD ? 2 : 3;
    x_stall = (hit(ea, RsD) && et > urs) || (hit(ma, RsD) && mt > urs) ||
              (hit(ea, RtD) && et > urt) || (hit(ma, RtD) && mt > urt);
    x_rsd = hit(ea, RsD) ? ((et == 0) ? 2'd3 : 2'd0) :
            hit(ma, RsD) ? ((mt == 0) ? 2'd1 : 2'd0) :
            hit(wa, RsD) ? ((wt == 0) ? 2'd2 : 2'd0) : 2'd0;
    x_rtd = hit(ea, RtD) ? ((et == 0) ? 2'd3 : 2'd0) :
            hit(ma, RtD) ? ((mt == 0) ? 2'd1 : 2'd0) :
            hit(wa, RtD) ? ((wt == 0) ? 2'd2 : 2'd0) : 2'd0;
    x_rse = hit(ma, RsE) ? ((mt == 0) ? 2'd1 : 2'd0) : hit(wa, RsE) ? 2'd2 : 2'd0;
    x_rte = hit(ma, RtE) ? ((mt == 0) ? 2'd1 : 2'd0) : hit(wa, RtE) ? 2'd2 : 2'd0;
    x_rtm = hit(wa, rtm);
    if (reset) begin
      x_stall = 1'b0; x_rtm = 1'b0;
      x_rsd = 2'd0; x_rtd = 2'd0; x_rse = 2'd0; x_rte = 2'd0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    calc();
    chk({tag, ".StallF"}, 32'(StallF), 32'(x_stall));
    chk({tag, ".StallD"}, 32'(StallD), 32'(x_stall));
    chk({tag, ".FlushE"}, 32'(FlushE), 32'(x_stall));
    chk({tag, ".FwdRSD"}, 32'(ForwardRSD), 32'(x_rsd));
    chk({tag, ".FwdRTD"}, 32'(ForwardRTD), 32'(x_rtd));
    chk({tag, ".FwdRSE"}, 32'(ForwardRSE), 32'(x_rse));
    chk({tag, ".FwdRTE"}, 32'(ForwardRTE), 32'(x_rte));
    chk({tag, ".FwdRTM"}, 32'(ForwardRTM), 32'(x_rtm));
`ifdef HAZARD_PERF_EN
    chk({tag, ".stall_cnt"}, stall_cnt, m_scnt);
    chk({tag, ".flush_cnt"}, flush_cnt, m_fcnt);
`endif
  endtask

  // Model update for the posedge that follows a check
  task automatic advance();
    issue_t it;
    if (reset) begin
      hist.delete(); m_scnt = 0; m_fcnt = 0;
      return;
    end
    calc();
    if (x_stall) begin m_scnt++; m_fcnt++; end
    it.dest = e_dest(); it.tnew = e_tnew(); it.rt = RtE;
    hist.push_front(it);
    if (hist.size() > 2) void'(hist.pop_back());
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input int kind);
    RsD = rs; RtD = rt;
    {branchD, jrD, cal_rD, cal_iD, ldD, stD} = 6'b0;
    case (kind)
      1: cal_rD = 1'b1;
      2: cal_iD = 1'b1;
      3: ldD = 1'b1;
      4: stD = 1'b1;
      5: branchD = 1'b1;
      6: jrD = 1'b1;
      default: ;
    endcase
  endtask

  task automatic set_e(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [1:0] dst, input logic rw, input logic [1:0] m2r);
    RsE = rs; RtE = rt; RdE = rd; RegDstE = dst; RegWriteE = rw; MemtoRegE = m2r;
  endtask

  // Check at negedge+2, clock the model, then return at the next negedge to drive
  task automatic step(input string tag);
    #2;
    check_all(tag);
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 5'd31 : (r == 4) ? 5'd0 : 5'(r);
  endfunction

  initial begin
    reset = 1'b1;
    set_d(5'd0, 5'd0, 0);
    set_e(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'b00);
    hist.delete(); m_scnt = 0; m_fcnt = 0;
    @(negedge clk);
    // Reset with a live producer/consumer pair still shows all outputs low
    set_e(5'd0, 5'd8, 5'd0, 2'b00, 1'b1, 2'b01);
    set_d(5'd8, 5'd0, 1);
    #2;
    chk("reset_stall", 32'(StallD), 32'd0);
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
    set_d(5'd0, 5'd0, 0);
    set_e(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'b00);
    step("idle");

    // Load-use: lw $8 in E, addu rs=8 in D
    set_e(5'd0, 5'd8, 5'd0, 2'b00, 1'b1, 2'b01);
    set_d(5'd8, 5'd1, 1);
    #2; chk("lu_stall", 32'(StallF), 32'd1); chk("lu_flush", 32'(FlushE), 32'd1); #(-0);
    step("lu0");
    set_e(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'b00);
    #2; chk("lu_release", 32'(StallD), 32'd0);
    step("lu1");
    set_e(5'd8, 5'd1, 5'd3, 2'b01, 1'b1, 2'b00);
    set_d(5'd0, 5'd0, 0);
    #2; chk("lu_fwd_rse", 32'(ForwardRSE), 32'd2);
    step("lu2");

    // beq rs=9 behind ori $9
    set_e(5'd0, 5'd9, 5'd0, 2'b00, 1'b1, 2'b00);
    set_d(5'd9, 5'd2, 5);
    #2; chk("beq_stall", 32'(StallD), 32'd1);
    step("beq0");
    set_e(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'b00);
    #2; chk("beq_nostall", 32'(StallD), 32'd0); chk("beq_fwd_m", 32'(ForwardRSD), 32'd1);
    step("beq1");

    // jal in E, jr $31 in D
    set_e(5'd0, 5'd0, 5'd0, 2'b10, 1'b1, 2'b10);
    set_d(5'd31, 5'd0, 6);
    #2; chk("jr_stall", 32'(StallD), 32'd0); chk("jr_fwd_pc8", 32'(ForwardRSD), 32'd3);
    step("jr");

    // sw rt=10 in D, lw $10 in E
    set_e(5'd0, 5'd10, 5'd0, 2'b00, 1'b1, 2'b01);
    set_d(5'd0, 5'd10, 4);
    #2; chk("sw_nostall", 32'(StallD), 32'd0);
    step("sw0");
    set_e(5'd0, 5'd10, 5'd0, 2'b00, 1'b0, 2'b00);
    set_d(5'd0, 5'd0, 0);
    step("sw1");
    set_e(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'b00);
    #2; chk("sw_fwd_rtm", 32'(ForwardRTM), 32'd1);
    step("sw2");
    step("sw3");

    // Producer targeting $0
    set_e(5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 2'b01);
    set_d(5'd0, 5'd0, 1);
    #2; chk("r0_stall", 32'(StallD), 32'd0); chk("r0_fwd", 32'(ForwardRSD), 32'd0);
    step("r0");

    // Reset during a load-use stall
    set_e(5'd0, 5'd8, 5'd0, 2'b00, 1'b1, 2'b01);
    set_d(5'd8, 5'd0, 1);
    #2; chk("rst_pre", 32'(StallD), 32'd1);
    #1; reset = 1'b1; #1;
    chk("rst_async_stall", 32'(StallF), 32'd0);
    chk("rst_async_flush", 32'(FlushE), 32'd0);
    advance();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_e(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'b00);
    #2; chk("rst_after", 32'(StallD), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("rst_cnt", stall_cnt, 32'd0);
`endif
    step("rst_after");
    step("rst_hold");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_d(pick_reg(), pick_reg(), $urandom_range(0, 6));
      set_e(pick_reg(), pick_reg(), pick_reg(), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
